// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame geometry and FSM state encoding.
// Used by the SPI write controller and the peripheral register file.
package spi_pkg;

  localparam int   FRAME_W   = 16;
  localparam int   ADDR_W    = 7;
  localparam int   DATA_W    = 8;
  localparam logic WRITE_BIT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

endpackage

// File: rtl/spi_controller_if.sv
// Request side (start/addr/data/busy/done) plus SPI pins of the controller.
// master: the SPI controller itself; slave: the requester / link observer.
interface spi_controller_if;
  import spi_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              cs_n;
  logic              copi;

  modport master (
    input  start, addr, data,
    output busy, done, sclk, cs_n, copi
  );

  modport slave (
    output start, addr, data,
    input  busy, done, sclk, cs_n, copi
  );

endinterface

// File: rtl/spi_clk_div.sv
// Tick generator: pulses tick every CLK_DIV enabled cycles.
// Ports: clk, rst_n, en (count), clr (sync clear), tick (on wrap).
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write controller: one 16-bit {W, addr, data} frame per start.
// Ports: clk, rst_n, bus (start/addr/data in; busy/done/sclk/cs_n/copi out).
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.master bus
);

  spi_state_t         state;
  logic [FRAME_W-2:0] shreg;
  logic [4:0]         edge_cnt;
  logic               tick;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state != IDLE),
    .clr  (state == IDLE),
    .tick (tick)
  );

  // edge_cnt holds the index of the last sclk edge issued (even = rise).
  // Once all 32 edges are out, SHIFT waits one more tick with sclk low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      edge_cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sclk <= 1'b0;
      bus.cs_n <= 1'b1;
      bus.copi <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SETUP;
            bus.busy <= 1'b1;
            bus.cs_n <= 1'b0;
            bus.copi <= WRITE_BIT;
            shreg    <= {bus.addr, bus.data};
            edge_cnt <= '0;
          end
        end
        SETUP: begin
          if (tick) begin
            state    <= SHIFT;
            bus.sclk <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (edge_cnt == 5'd31) begin
              state <= HOLD;
            end else begin
              edge_cnt <= edge_cnt + 5'd1;
              bus.sclk <= ~bus.sclk;
              if (bus.sclk && edge_cnt != 5'd30) begin
                bus.copi <= shreg[FRAME_W-2];
                shreg    <= {shreg[FRAME_W-3:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state    <= GAP;
            bus.cs_n <= 1'b1;
            bus.copi <= 1'b0;
          end
        end
        GAP: begin
          if (tick) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller (CLK_DIV=4 and 1) with a
// peripheral model capturing frames into a scoreboard.
module tb_spi_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_controller_if i4 ();
  spi_controller_if i1 ();

  spi_controller #(.CLK_DIV(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (i4)
  );

  spi_controller #(.CLK_DIV(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (i1)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] exp4[$];
  logic [15:0] got4[$];
  logic [15:0] exp1[$];
  logic [15:0] got1[$];
  logic [7:0]  regs[128];

  logic [15:0] sh4, sh1;
  int nb4 = 0, nb1 = 0;
  int part4 = 0, part1 = 0;
  int done4 = 0;
  int run = 0, gapw = 0;

  // Peripheral model: sample on sclk rise, commit on cs_n rise.
  always @(posedge i4.sclk) begin
    sh4 = {sh4[14:0], i4.copi};
    nb4++;
  end

  always @(posedge i4.cs_n) begin
    if (nb4 == 16) begin
      got4.push_back(sh4);
      regs[sh4[14:8]] = sh4[7:0];
    end else if (nb4 != 0) begin
      part4++;
    end
    nb4 = 0;
  end

  always @(posedge i1.sclk) begin
    sh1 = {sh1[14:0], i1.copi};
    nb1++;
  end

  always @(posedge i1.cs_n) begin
    if (nb1 == 16) got1.push_back(sh1);
    else if (nb1 != 0) part1++;
    nb1 = 0;
  end

  always @(negedge clk) begin
    if (i4.done === 1'b1) done4++;
    if (i4.cs_n === 1'b1) begin
      run++;
    end else begin
      if (run > 0) gapw = run;
      run = 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame4(input logic [6:0] a,
                        input logic [7:0] d,
                        input logic [15:0] e,
                        input int inj,
                        input bit now,
                        output int bc);
    if (!now) @(negedge clk);
    i4.start = 1'b1;
    i4.addr  = a;
    i4.data  = d;
    exp4.push_back(e);
    @(negedge clk);
    i4.start = 1'b0;
    bc = 0;
    while (i4.busy === 1'b1 && bc < 2000) begin
      bc++;
      i4.start = (bc == inj);
      if (bc == inj) begin
        i4.addr = 7'h03;
        i4.data = 8'h11;
      end
      @(negedge clk);
    end
    i4.start = 1'b0;
  endtask

  task automatic pop4(input string tag);
    int k = 0;
    while (got4.size() == 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (got4.size() == 0 || exp4.size() == 0)
      chk({tag, "_missing"}, 32'(got4.size()), 1);
    else
      chk(tag, got4.pop_front(), exp4.pop_front());
  endtask

  initial begin
    int b, k, dc, tg;
    logic prev;
    i4.start = 1'b0;
    i4.addr  = '0;
    i4.data  = '0;
    i1.start = 1'b0;
    i1.addr  = '0;
    i1.data  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst4", {i4.cs_n, i4.sclk, i4.copi, i4.busy, i4.done}, 5'b10000);
    chk("rst1", {i1.cs_n, i1.sclk, i1.copi, i1.busy, i1.done}, 5'b10000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    frame4(7'h00, 8'hA5, 16'h80A5, -1, 1'b0, b);
    chk("busy_a", b, 140);
    chk("done_a", i4.done, 1'b1);
    pop4("frame_a");
    repeat (3) @(negedge clk);
    chk("donecnt_a", done4, 1);
    chk("rises_a", part4, 0);

    frame4(7'h00, 8'hA5, 16'h80A5, 40, 1'b0, b);
    chk("busy_mid", b, 140);
    pop4("frame_mid");
    repeat (3) @(negedge clk);
    chk("donecnt_mid", done4, 2);

    frame4(7'h01, 8'h3C, 16'h813C, -1, 1'b0, b);
    gapw = 0;
    frame4(7'h04, 8'hC3, 16'h84C3, -1, 1'b1, b);
    chk("busy_b2b", b, 140);
    pop4("frame_b2b_1");
    pop4("frame_b2b_2");
    chk("gap_ge4", gapw >= 4, 1);
    repeat (3) @(negedge clk);
    chk("donecnt_b2b", done4, 4);

    dc = done4;
    @(negedge clk);
    i4.start = 1'b1;
    i4.addr  = 7'h06;
    i4.data  = 8'h77;
    @(negedge clk);
    i4.start = 1'b0;
    k = 0;
    while (nb4 < 7 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("rise7_seen", nb4, 7);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {i4.cs_n, i4.sclk, i4.copi, i4.busy, i4.done}, 5'b10000);
    repeat (20) @(negedge clk);
    chk("rst_nodone", done4, dc);
    chk("rst_partial", part4, 1);
    rst_n = 1'b1;
    frame4(7'h02, 8'h55, 16'h8255, -1, 1'b0, b);
    chk("busy_post", b, 140);
    pop4("frame_post");

    @(negedge clk);
    i1.start = 1'b1;
    i1.addr  = 7'h7F;
    i1.data  = 8'hFF;
    exp1.push_back(16'hFFFF);
    @(negedge clk);
    i1.start = 1'b0;
    b = 0;
    tg = 0;
    prev = i1.sclk;
    while (i1.busy === 1'b1 && b < 500) begin
      b++;
      if (i1.sclk !== prev) tg++;
      prev = i1.sclk;
      @(negedge clk);
    end
    chk("busy_d1", b, 35);
    chk("done_d1", i1.done, 1'b1);
    chk("toggles_d1", tg, 32);
    if (got1.size() == 0 || exp1.size() == 0)
      chk("frame_d1_missing", 32'(got1.size()), 1);
    else
      chk("frame_d1", got1.pop_front(), exp1.pop_front());
    chk("partial_d1", part1, 0);

    frame4(7'h04, 8'h5A, 16'h845A, -1, 1'b0, b);
    pop4("frame_lb");
    chk("reg4", regs[4], 8'h5A);
    chk("sb_left", 32'(got4.size() + exp4.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
